// File: rtl/pe_array_ctrl_if.sv
// Interface between the tile scheduler / array side and the PE array sequencer.
// The master modport is the scheduler/array side; the slave modport is the
// sequencer. With PE_CTRL_PERF_EN defined, the interface also carries
// perf_cycles.
interface pe_array_ctrl_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int K_W  = 10
) ();
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            start;
  logic [K_W-1:0]  k_len;
  logic            opsel_cfg;
  logic            abort;
  logic            busy;
  logic            done;
  logic            arr_en;
  logic            arr_w_en;
  logic            arr_selector;
  logic            arr_opsel;
  logic            w_rd_valid;
  logic [AW-1:0]   w_rd_addr;
  logic            act_rd_valid;
  logic [K_W-1:0]  act_rd_addr;
  logic [COLS-1:0] out_col_en;
  logic [K_W-1:0]  out_vec_idx;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]     perf_cycles;

  modport master (
    output start, k_len, opsel_cfg, abort,
    input  busy, done, arr_en, arr_w_en, arr_selector, arr_opsel,
    input  w_rd_valid, w_rd_addr, act_rd_valid, act_rd_addr,
    input  out_col_en, out_vec_idx, perf_cycles
  );

  modport slave (
    input  start, k_len, opsel_cfg, abort,
    output busy, done, arr_en, arr_w_en, arr_selector, arr_opsel,
    output w_rd_valid, w_rd_addr, act_rd_valid, act_rd_addr,
    output out_col_en, out_vec_idx, perf_cycles
  );
`else
  modport master (
    output start, k_len, opsel_cfg, abort,
    input  busy, done, arr_en, arr_w_en, arr_selector, arr_opsel,
    input  w_rd_valid, w_rd_addr, act_rd_valid, act_rd_addr,
    input  out_col_en, out_vec_idx
  );

  modport slave (
    input  start, k_len, opsel_cfg, abort,
    output busy, done, arr_en, arr_w_en, arr_selector, arr_opsel,
    output w_rd_valid, w_rd_addr, act_rd_valid, act_rd_addr,
    output out_col_en, out_vec_idx
  );
`endif
endinterface

// File: rtl/pe_array_ctrl.sv
// Weight-stationary systolic PE array sequencer.
// For each tile it loads ROWS weight rows, then streams k_len activation
// vectors and drains the array, opening per-column output-valid windows.
// Every output comes from a flop. Output values are decoded from the next
// state and count, so the strobes line up with the state they belong to.
// Optional macro PE_CTRL_PERF_EN adds a saturating busy-cycle counter
// (perf_cycles).
module pe_array_ctrl #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int K_W  = 10
) (
  input  logic            CLK,
  input  logic            RESET,
  pe_array_ctrl_if.slave  bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = K_W + 1;
  localparam int XW = K_W + 2;

  localparam logic [CW-1:0] ROWS_C      = CW'(ROWS);
  localparam logic [CW-1:0] LOAD_LAST_C = CW'(ROWS - 1);
  localparam logic [CW-1:0] TAIL_C      = CW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nx_s;
  logic [K_W-1:0]  k_len_r;
  logic            opsel_r;
  logic            accept_s;
  logic            opsel_nx_s;
  logic [CW-1:0]   last_cnt_s;

  logic            busy_nx_s;
  logic            done_nx_s;
  logic            en_nx_s;
  logic            w_en_nx_s;
  logic            sel_nx_s;
  logic            arr_opsel_nx_s;
  logic            w_valid_nx_s;
  logic [AW-1:0]   w_addr_nx_s;
  logic            act_valid_nx_s;
  logic [K_W-1:0]  act_addr_nx_s;
  logic [COLS-1:0] col_en_nx_s;
  logic [K_W-1:0]  vec_idx_nx_s;

  logic            busy_r;
  logic            done_r;
  logic            en_r;
  logic            w_en_r;
  logic            sel_r;
  logic            arr_opsel_r;
  logic            w_valid_r;
  logic [AW-1:0]   w_addr_r;
  logic            act_valid_r;
  logic [K_W-1:0]  act_addr_r;
  logic [COLS-1:0] col_en_r;
  logic [K_W-1:0]  vec_idx_r;

  // A tile is accepted only from IDLE and only with a non-empty vector count.
  assign accept_s   = (state_r == IDLE) && bus.start && (bus.k_len != {K_W{1'b0}});
  // Last COMPUTE count is k_len + ROWS + COLS - 2 (fill plus drain of the array).
  assign last_cnt_s = {1'b0, k_len_r} + TAIL_C;
  // The first LOAD_W cycle must already show the newly latched opsel.
  assign opsel_nx_s = accept_s ? bus.opsel_cfg : opsel_r;

  // State and counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Latch the tile configuration on an accepted start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      k_len_r <= {K_W{1'b0}};
      opsel_r <= 1'b0;
    end else if (accept_s) begin
      k_len_r <= bus.k_len;
      opsel_r <= bus.opsel_cfg;
    end else begin
      k_len_r <= k_len_r;
      opsel_r <= opsel_r;
    end
  end

  // Next-state and next-count decode; abort outranks the normal transition.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = LOAD_W;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end
      end
      LOAD_W: begin
        if (bus.abort) begin
          state_nx_s = IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end else if (cnt_r == LOAD_LAST_C) begin
          state_nx_s = COMPUTE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = LOAD_W;
          cnt_nx_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      COMPUTE: begin
        if (bus.abort) begin
          state_nx_s = IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end else if (cnt_r == last_cnt_s) begin
          state_nx_s = DONE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = COMPUTE;
          cnt_nx_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the next state/count; the values are registered below.
  always_comb begin
    busy_nx_s      = 1'b0;
    done_nx_s      = 1'b0;
    en_nx_s        = 1'b0;
    w_en_nx_s      = 1'b0;
    sel_nx_s       = 1'b0;
    arr_opsel_nx_s = 1'b0;
    w_valid_nx_s   = 1'b0;
    w_addr_nx_s    = {AW{1'b0}};
    act_valid_nx_s = 1'b0;
    act_addr_nx_s  = {K_W{1'b0}};
    col_en_nx_s    = {COLS{1'b0}};
    vec_idx_nx_s   = {K_W{1'b0}};
    case (state_nx_s)
      IDLE: begin
        busy_nx_s = 1'b0;
      end
      LOAD_W: begin
        busy_nx_s      = 1'b1;
        en_nx_s        = 1'b1;
        w_en_nx_s      = 1'b1;
        sel_nx_s       = 1'b1;
        arr_opsel_nx_s = opsel_nx_s;
        w_valid_nx_s   = 1'b1;
        w_addr_nx_s    = cnt_nx_s[AW-1:0];
      end
      COMPUTE: begin
        busy_nx_s      = 1'b1;
        en_nx_s        = 1'b1;
        arr_opsel_nx_s = opsel_r;
        // Activations enter unskewed for the first k_len counts.
        if (cnt_nx_s < {1'b0, k_len_r}) begin
          act_valid_nx_s = 1'b1;
          act_addr_nx_s  = cnt_nx_s[K_W-1:0];
        end else begin
          act_valid_nx_s = 1'b0;
          act_addr_nx_s  = {K_W{1'b0}};
        end
        // Column c emits after ROWS+c cycles of skew, for k_len cycles.
        for (int c = 0; c < COLS; c++) begin
          col_en_nx_s[c] = ({1'b0, cnt_nx_s} >= XW'(ROWS + c)) &&
                           ({1'b0, cnt_nx_s} < (XW'(ROWS + c) + {2'b00, k_len_r}));
        end
        if (col_en_nx_s[0]) begin
          vec_idx_nx_s = K_W'(cnt_nx_s - ROWS_C);
        end else begin
          vec_idx_nx_s = {K_W{1'b0}};
        end
      end
      DONE: begin
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      en_r        <= 1'b0;
      w_en_r      <= 1'b0;
      sel_r       <= 1'b0;
      arr_opsel_r <= 1'b0;
      w_valid_r   <= 1'b0;
      w_addr_r    <= {AW{1'b0}};
      act_valid_r <= 1'b0;
      act_addr_r  <= {K_W{1'b0}};
      col_en_r    <= {COLS{1'b0}};
      vec_idx_r   <= {K_W{1'b0}};
    end else begin
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      en_r        <= en_nx_s;
      w_en_r      <= w_en_nx_s;
      sel_r       <= sel_nx_s;
      arr_opsel_r <= arr_opsel_nx_s;
      w_valid_r   <= w_valid_nx_s;
      w_addr_r    <= w_addr_nx_s;
      act_valid_r <= act_valid_nx_s;
      act_addr_r  <= act_addr_nx_s;
      col_en_r    <= col_en_nx_s;
      vec_idx_r   <= vec_idx_nx_s;
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.arr_en       = en_r;
  assign bus.arr_w_en     = w_en_r;
  assign bus.arr_selector = sel_r;
  assign bus.arr_opsel    = arr_opsel_r;
  assign bus.w_rd_valid   = w_valid_r;
  assign bus.w_rd_addr    = w_addr_r;
  assign bus.act_rd_valid = act_valid_r;
  assign bus.act_rd_addr  = act_addr_r;
  assign bus.out_col_en   = col_en_r;
  assign bus.out_vec_idx  = vec_idx_r;

`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_r;

  // Saturating count of busy cycles, cleared by each accepted start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      perf_r <= 32'd0;
    end else if (accept_s) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perf_cycles = perf_r;
`endif
endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for the weight-stationary systolic PE array. It runs one tile operation per start: it loads ROWS weight rows into the array, then fetches k_len activation vectors. It generates the array control strobes (EN, W_EN, SELECTOR, OPSEL) and the per-column output-valid windows for the result collector. It sits between the tile scheduler (start/done) and the array plus its weight/activation buffers.

Parameters:
ROWS, 16, number of PE rows (matches array num1)
COLS, 16, number of PE columns (matches array num2)
K_W, 10, width of k_len; ROWS+COLS must be at most 2^K_W

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
start  in  1  start pulse; sampled only in IDLE
k_len  in  K_W  number of activation vectors in this tile; latched on accepted start
opsel_cfg  in  1  operation select for this tile; latched on accepted start
abort  in  1  synchronous abort; returns the block to IDLE next cycle
busy  out  1  high in LOAD_W and COMPUTE
done  out  1  one-cycle pulse at the end of the tile
arr_en  out  1  drives array EN
arr_w_en  out  1  drives array W_EN
arr_selector  out  1  drives array SELECTOR; 1 = weight shift path
arr_opsel  out  1  drives array OPSEL
w_rd_valid  out  1  weight buffer read strobe
w_rd_addr  out  $clog2(ROWS)  weight row address
act_rd_valid  out  1  activation buffer read strobe (unskewed)
act_rd_addr  out  K_W  activation vector index
out_col_en  out  COLS  bit c high while column c's out_sum_final slice is valid
out_vec_idx  out  K_W  vector index of column 0 output (cnt-ROWS)

Behaviour:
- FSM states: IDLE, LOAD_W, COMPUTE, DONE. Single counter cnt, width K_W+1.
- Reset values: state=IDLE, cnt=0, all outputs 0, latched k_len/opsel_cfg = 0.
- IDLE: start=1 and k_len!=0 -> LOAD_W next cycle, cnt=0, latch k_len and opsel_cfg. start with k_len==0 is ignored (stays IDLE, no done).
- LOAD_W: lasts exactly ROWS cycles.
  - Outputs: arr_en=1, arr_w_en=1, arr_selector=1, w_rd_valid=1, w_rd_addr=cnt.
  - At cnt==ROWS-1 -> COMPUTE, cnt=0.
- COMPUTE: lasts k_len+ROWS+COLS-1 cycles (cnt 0..k_len+ROWS+COLS-2).
  - Outputs: arr_en=1, arr_w_en=0, arr_selector=0.
  - act_rd_valid = (cnt<k_len); act_rd_addr=cnt when valid, else 0.
  - out_col_en[c] = (ROWS+c <= cnt < ROWS+c+k_len).
  - out_vec_idx = cnt-ROWS while out_col_en[0]=1, else 0.
  - At the last count -> DONE.
- DONE: done=1 for one cycle, all strobes 0; -> IDLE.
- arr_opsel = latched opsel while busy, 0 otherwise.
- busy is registered and high exactly in LOAD_W and COMPUTE.
- start while busy or in DONE: ignored, not queued.
- abort (any non-IDLE state): next cycle IDLE, cnt=0, all strobes 0, no done pulse. abort has priority over the state transition in the same cycle. abort in IDLE: no effect.
- abort and start together in IDLE: start is accepted.
- RESET asserted mid-operation: immediate return to reset values; no done.
- All outputs are registered (Moore); there is no combinational path from inputs to outputs.

Optional Feature:
Macro PE_CTRL_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It counts cycles with busy=1 and saturates at 0xFFFFFFFF. It clears on RESET and on each accepted start, and holds its value after done or abort.
- Undefined: no port and no counter logic.

Test Plan:
- ROWS=4, COLS=4, k_len=3, start at cycle 0 -> LOAD_W cycles 1-4 (w_rd_addr 0..3); COMPUTE cycles 5-14; act_rd_valid cycles 5-7; out_col_en[0] cycles 9-11; out_col_en[3] cycles 12-14; done at cycle 15; busy cycles 1-14.
- k_len=0 with start -> state stays IDLE; busy, done, and all strobes stay 0.
- Second start during COMPUTE -> ignored; exactly one done; arr_opsel keeps the first tile's value.
- abort at the 3rd COMPUTE cycle -> next cycle all outputs 0, no done; a new start with k_len=1 then completes in 4+(1+4+4-1)+1 cycles.
- RESET pulse during LOAD_W -> outputs 0 immediately (asynchronously); start after reset release behaves as a fresh tile.
- PE_CTRL_PERF_EN defined, same tile as scenario 1 -> perf_cycles=14 after done; a later start clears it to 0.
